// File: rtl/game_sprite_display_if.sv
// game_sprite_display_if: beam, write-staging and pixel-output signals of one sprite source.
`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 3
`endif
interface game_sprite_display_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10
);
  logic [X_WIDTH-1:0] pixel_x_i;
  logic [Y_WIDTH-1:0] pixel_y_i;
  logic display_on_i;
  logic frame_start_i;
  logic write_i;
  logic [X_WIDTH-1:0] write_x_i;
  logic [Y_WIDTH-1:0] write_y_i;
  logic [X_WIDTH-1:0] write_dx_i;
  logic [Y_WIDTH-1:0] write_dy_i;
  logic motion_en_i;
  logic [X_WIDTH-1:0] sprite_x_o;
  logic [Y_WIDTH-1:0] sprite_y_o;
  logic sprite_within_screen_o;
  logic rgb_en_o;
  logic [`GAME_RGB_WIDTH-1:0] rgb_o;
  modport slave (
    input pixel_x_i, pixel_y_i, display_on_i, frame_start_i, write_i,
          write_x_i, write_y_i, write_dx_i, write_dy_i, motion_en_i,
    output sprite_x_o, sprite_y_o, sprite_within_screen_o, rgb_en_o, rgb_o
  );
  modport master (
    output pixel_x_i, pixel_y_i, display_on_i, frame_start_i, write_i,
           write_x_i, write_y_i, write_dx_i, write_dy_i, motion_en_i,
    input sprite_x_o, sprite_y_o, sprite_within_screen_o, rgb_en_o, rgb_o
  );
endinterface

// File: rtl/game_sprite_display.sv
// game_sprite_display: tear-free sprite position/velocity with a 2-stage bitmap pixel pipeline.
`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 3
`endif
module game_sprite_display #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10,
  parameter int SCREEN_WIDTH = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SPRITE_WIDTH = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter logic [SPRITE_WIDTH*SPRITE_HEIGHT-1:0] SPRITE_MASK = '1,
  parameter logic [`GAME_RGB_WIDTH-1:0] SPRITE_RGB = 3'b100,
  parameter logic [X_WIDTH-1:0] START_X = '0,
  parameter logic [Y_WIDTH-1:0] START_Y = '0,
  parameter logic [X_WIDTH-1:0] START_DX = '0,
  parameter logic [Y_WIDTH-1:0] START_DY = '0
) (
  input logic clk,
  input logic rst_n,
  game_sprite_display_if.slave bus
);
  localparam int RX = $clog2(SPRITE_WIDTH);
  localparam int RY = $clog2(SPRITE_HEIGHT);
  localparam int MW = $clog2(SPRITE_WIDTH*SPRITE_HEIGHT);
  localparam int X1 = X_WIDTH + 1;
  localparam int Y1 = Y_WIDTH + 1;
  logic [X_WIDTH-1:0] x_q, dx_q, px_q, pdx_q, diff_x;
  logic [Y_WIDTH-1:0] y_q, dy_q, py_q, pdy_q, diff_y;
  logic pend_q, win_q, win_d, hit_q, hit_d, en_q, en_d;
  logic [RX-1:0] rel_x_q, rel_x_d;
  logic [RY-1:0] rel_y_q, rel_y_d;
  logic [MW-1:0] idx;
  always_comb begin
    diff_x = bus.pixel_x_i - x_q;
    diff_y = bus.pixel_y_i - y_q;
    rel_x_d = RX'(diff_x);
    rel_y_d = RY'(diff_y);
    hit_d = bus.display_on_i
          & (bus.pixel_x_i >= x_q) & (diff_x < X_WIDTH'(SPRITE_WIDTH))
          & (bus.pixel_y_i >= y_q) & (diff_y < Y_WIDTH'(SPRITE_HEIGHT));
    win_d = ({1'b0, x_q} + X1'(SPRITE_WIDTH) <= X1'(SCREEN_WIDTH))
          & ({1'b0, y_q} + Y1'(SPRITE_HEIGHT) <= Y1'(SCREEN_HEIGHT));
    idx = MW'(rel_y_q) * MW'(SPRITE_WIDTH) + MW'(rel_x_q);
    en_d = hit_q & SPRITE_MASK[idx];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= START_X;
      y_q <= START_Y;
      dx_q <= START_DX;
      dy_q <= START_DY;
      px_q <= '0;
      py_q <= '0;
      pdx_q <= '0;
      pdy_q <= '0;
      pend_q <= 1'b0;
      win_q <= 1'b0;
      rel_x_q <= '0;
      rel_y_q <= '0;
      hit_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      // A write in the frame_start cycle wins over both staged data and motion.
      if (bus.frame_start_i) begin
        if (bus.write_i) begin
          x_q <= bus.write_x_i;
          y_q <= bus.write_y_i;
          dx_q <= bus.write_dx_i;
          dy_q <= bus.write_dy_i;
          pend_q <= 1'b0;
        end else if (pend_q) begin
          x_q <= px_q;
          y_q <= py_q;
          dx_q <= pdx_q;
          dy_q <= pdy_q;
          pend_q <= 1'b0;
        end else if (bus.motion_en_i) begin
          x_q <= x_q + dx_q;
          y_q <= y_q + dy_q;
        end
      end else if (bus.write_i) begin
        px_q <= bus.write_x_i;
        py_q <= bus.write_y_i;
        pdx_q <= bus.write_dx_i;
        pdy_q <= bus.write_dy_i;
        pend_q <= 1'b1;
      end
      win_q <= win_d;
      rel_x_q <= rel_x_d;
      rel_y_q <= rel_y_d;
      hit_q <= hit_d;
      en_q <= en_d;
    end
  end
  assign bus.sprite_x_o = x_q;
  assign bus.sprite_y_o = y_q;
  assign bus.sprite_within_screen_o = win_q;
  assign bus.rgb_en_o = en_q;
  assign bus.rgb_o = en_q ? SPRITE_RGB : '0;
endmodule
